// File: rtl/square_accum_window_ctrl_pkg.sv
// sqacc_ctrl_pkg: shared widths and controller state encoding for square_accum_window_ctrl
package sqacc_ctrl_pkg;
   localparam int IN_WIDTH  = 4;
   localparam int ACC_WIDTH = 24;
   typedef enum logic [2:0] {IDLE, RUN, DRAIN, CAPTURE, HOLD, CLR} state_t;
endpackage

// File: rtl/square_accum_window_ctrl_accum.sv
// square_5bit_accumulator: pipelined sum of squares, result visible LAT enabled cycles after in_i
module square_5bit_accumulator
   import sqacc_ctrl_pkg::*;
#(
   parameter int LAT = 3
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 ce_i,
   input  logic [4:0]           in_i,
   output logic [ACC_WIDTH-1:0] accum_o
);
   logic [9:0] sq_q [LAT-1];
   // Square, delay LAT-2 stages, then accumulate; everything advances only on ce_i.
   always_ff @(posedge clk_i)
      if (rst_i) begin
         for (int i = 0; i < LAT - 1; i++) sq_q[i] <= '0;
         accum_o <= '0;
      end else if (ce_i) begin
         sq_q[0] <= 10'(in_i) * 10'(in_i);
         for (int i = 1; i < LAT - 1; i++) sq_q[i] <= sq_q[i-1];
         accum_o <= accum_o + ACC_WIDTH'(sq_q[LAT-2]);
      end
endmodule

// File: rtl/square_accum_window_ctrl.sv
// square_accum_window_ctrl: windowed sum-of-squares controller around one square_5bit_accumulator.
// Build option SQACC_CTRL_OVERRUN_EN: capture overwrites an unconsumed result and sets overrun_o; otherwise capture stalls.
module square_accum_window_ctrl
   import sqacc_ctrl_pkg::*;
#(
   parameter int LEN_WIDTH   = 16,
   parameter int ACC_LATENCY = 3
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 en_i,
   input  logic [LEN_WIDTH-1:0] win_len_i,
   input  logic [IN_WIDTH-1:0]  in_i,
   input  logic                 in_valid_i,
   output logic                 in_ready_o,
   output logic [ACC_WIDTH-1:0] power_o,
   output logic [LEN_WIDTH-1:0] count_o,
   output logic                 power_valid_o,
   input  logic                 power_ready_i,
   output logic                 overrun_o
);
   localparam int DW = $clog2(ACC_LATENCY + 1);
   state_t state, nxt;
   logic [LEN_WIDTH-1:0] len_q, cnt_q, cnt_nx;
   logic [DW-1:0] drn_q;
   logic accept, slot_free, start, take, cap_q, acc_ce, acc_rst;
   logic [4:0] acc_in;
   logic [ACC_WIDTH-1:0] acc;
   assign in_ready_o = state == RUN;
   assign accept     = in_valid_i && in_ready_o;
   assign cnt_nx     = cnt_q + 1'b1;
   assign start      = (state == IDLE || state == CLR) && nxt == RUN;
   assign take       = state == CAPTURE && slot_free;
`ifdef SQACC_CTRL_OVERRUN_EN
   assign slot_free = 1'b1;
`else
   assign slot_free = !power_valid_o || power_ready_i;
   assign overrun_o = 1'b0;
`endif
   square_5bit_accumulator #(.LAT(ACC_LATENCY)) u_acc (
      .clk_i   (clk_i),
      .rst_i   (acc_rst),
      .ce_i    (acc_ce),
      .in_i    (acc_in),
      .accum_o (acc)
   );
   // Next state plus accumulator controls; reset forces the accumulator clear and freezes ce.
   always_comb begin
      nxt     = state;
      acc_rst = rst_i || state == CLR;
      acc_ce  = !rst_i && (accept || state == DRAIN);
      acc_in  = accept ? {1'b0, in_i} : '0;
      case (state)
         IDLE:    nxt = en_i ? RUN : IDLE;
         RUN:     nxt = !en_i ? HOLD : (accept && cnt_nx == len_q) ? DRAIN : RUN;
         DRAIN:   nxt = drn_q == DW'(ACC_LATENCY - 1) ? CAPTURE : DRAIN;
         CAPTURE: nxt = slot_free ? HOLD : CAPTURE;
         HOLD:    nxt = CLR;
         CLR:     nxt = en_i ? RUN : IDLE;
         default: nxt = IDLE;
      endcase
   end
   // State register, window length latch, sample counter and drain timer.
   always_ff @(posedge clk_i)
      if (rst_i) begin
         state <= IDLE;
         len_q <= '0;
         cnt_q <= '0;
         drn_q <= '0;
      end else begin
         state <= nxt;
         drn_q <= state == DRAIN ? drn_q + 1'b1 : '0;
         if (start) begin
            len_q <= win_len_i == '0 ? LEN_WIDTH'(1) : win_len_i;
            cnt_q <= '0;
         end else if (accept) cnt_q <= cnt_nx;
      end
   // Result slot: data latched on leaving CAPTURE, valid raised one edge later, cleared on handshake.
   always_ff @(posedge clk_i)
      if (rst_i) begin
         power_o       <= '0;
         count_o       <= '0;
         power_valid_o <= 1'b0;
         cap_q         <= 1'b0;
      end else begin
         cap_q         <= take;
         power_valid_o <= cap_q || (power_valid_o && !power_ready_i);
         if (take) begin
            power_o <= acc;
            count_o <= cnt_q;
         end
      end
`ifdef SQACC_CTRL_OVERRUN_EN
   // Sticky flag for a capture that lands on a result nobody has taken yet.
   always_ff @(posedge clk_i)
      if (rst_i) overrun_o <= 1'b0;
      else if (state == CAPTURE && power_valid_o && !power_ready_i) overrun_o <= 1'b1;
`endif
endmodule

// File: tb/tb_square_accum_window_ctrl.sv
// tb_square_accum_window_ctrl: randomized and directed windows checked against a sum-of-squares model
module tb_square_accum_window_ctrl;
   import sqacc_ctrl_pkg::*;
   localparam int LAT = 3;
   logic clk = 1'b0, rst = 1'b1, en = 1'b0, in_valid = 1'b0, power_ready = 1'b0;
   logic [15:0] win_len = '0;
   logic [3:0] in_v = '0;
   logic in_ready, power_valid, overrun;
   logic [23:0] power;
   logic [15:0] count;
   int checks = 0, errors = 0, cyc = 0, last_acc = 0, rise_cyc = 0, rises = 0, rst_pulses = 0;
   int exp_sum = 0, exp_n = 0;
   logic pv_prev = 1'b0, ar_prev = 1'b0;
   int got_pow[$], got_cnt[$];

   square_accum_window_ctrl #(.LEN_WIDTH(16), .ACC_LATENCY(LAT)) dut (
      .clk_i(clk), .rst_i(rst), .en_i(en), .win_len_i(win_len), .in_i(in_v),
      .in_valid_i(in_valid), .in_ready_o(in_ready), .power_o(power), .count_o(count),
      .power_valid_o(power_valid), .power_ready_i(power_ready), .overrun_o(overrun)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Passive observer: valid rises, accumulator clear pulses, completed output handshakes.
   always @(negedge clk) begin
      if (power_valid && !pv_prev) begin rise_cyc = cyc; rises++; end
      pv_prev = power_valid;
      if (dut.acc_rst && !ar_prev) rst_pulses++;
      ar_prev = dut.acc_rst;
      if (power_valid && power_ready) begin
         got_pow.push_back(int'(power));
         got_cnt.push_back(int'(count));
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start(input logic [15:0] len);
      en = 1'b0;
      repeat (8) tick();
      win_len = len;
      en = 1'b1;
      exp_sum = 0;
      exp_n = 0;
   endtask

   task automatic send(input logic [3:0] v, input int gap);
      int t = 0;
      repeat (gap) begin
         in_valid = 1'b0;
         #1;
         if (in_ready) chk("gap_ce", dut.acc_ce, 0);
         tick();
      end
      in_v = v;
      in_valid = 1'b1;
      while (!in_ready && t < 64) begin tick(); t++; end
      if (!in_ready) chk("ready_timeout", in_ready, 1);
      tick();
      last_acc = cyc;
      in_valid = 1'b0;
      exp_sum += int'(v) * int'(v);
      exp_n++;
   endtask

   task automatic collect(input string tag, input int p, input int n);
      int t = 0;
      while (got_pow.size() == 0 && t < 200) begin tick(); t++; end
      if (got_pow.size() == 0) chk({tag, "_timeout"}, got_pow.size(), 1);
      else begin
         chk({tag, "_power"}, got_pow.pop_front(), p);
         chk({tag, "_count"}, got_cnt.pop_front(), n);
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   initial begin
      int n, r0, q0, len;
      en = 1'b1;
      repeat (3) tick();
      chk("rst_ready", in_ready, 0);
      chk("rst_valid", power_valid, 0);
      chk("rst_power", power, 0);
      chk("rst_count", count, 0);
      chk("rst_overrun", overrun, 0);
      chk("rst_acc_rst", dut.acc_rst, 1);
      chk("rst_acc_ce", dut.acc_ce, 0);
      rst = 1'b0;
      power_ready = 1'b1;
      // Two-sample window with latency check.
      start(2);
      send(1, 0);
      send(2, 0);
      collect("w2", 5, 2);
      chk("w2_lat", rise_cyc - last_acc, LAT + 2);
      // Sixteen samples with periodic valid gaps.
      start(16);
      for (int v = 0; v < 16; v++) send(4'(v), (v % 3 == 2) ? 1 : 0);
      collect("w16", exp_sum, exp_n);
      chk("w16_lat", rise_cyc - last_acc, LAT + 2);
      // Random windows.
      for (int w = 0; w < 5; w++) begin
         len = $urandom_range(1, 6);
         start(16'(len));
         repeat (len) send(4'($urandom_range(0, 15)), $urandom_range(0, 2));
         collect("rnd", exp_sum, len);
         chk("rnd_lat", rise_cyc - last_acc, LAT + 2);
      end
      // Back-to-back windows with en held.
      start(4);
      for (int w = 0; w < 3; w++) begin
         repeat (4) send(4'd7, 0);
         n = 0;
         while (!in_ready && n < 20) begin tick(); n++; end
         chk("b2b_gap", n, LAT + 3);
      end
      repeat (3) collect("b2b", 196, 4);
      // Two windows with the consumer blocked.
      power_ready = 1'b0;
      start(2);
      send(3, 0);
      send(4, 0);
      send(1, 0);
      send(1, 0);
      repeat (20) tick();
`ifdef SQACC_CTRL_OVERRUN_EN
      chk("ovr_flag", overrun, 1);
      chk("ovr_power", power, 2);
      chk("ovr_valid", power_valid, 1);
      power_ready = 1'b1;
      collect("ovr", 2, 2);
`else
      chk("stall_ready", in_ready, 0);
      chk("stall_power", power, 25);
      chk("stall_count", count, 2);
      chk("stall_overrun", overrun, 0);
      power_ready = 1'b1;
      collect("stall1", 25, 2);
      collect("stall2", 2, 2);
`endif
      // Abort in RUN: no result, single accumulator clear.
      start(8);
      r0 = rst_pulses;
      q0 = rises;
      send(2, 0);
      send(3, 0);
      send(4, 0);
      en = 1'b0;
      repeat (10) tick();
      chk("abort_results", got_pow.size(), 0);
      chk("abort_rises", rises - q0, 0);
      chk("abort_clr", rst_pulses - r0, 1);
      start(1);
      send(5, 0);
      collect("single", 25, 1);
      // Reset while draining.
      start(4);
      repeat (4) send(4'($urandom_range(1, 15)), 0);
      q0 = rises;
      rst = 1'b1;
      tick();
      chk("mid_rst_power", power, 0);
      chk("mid_rst_count", count, 0);
      chk("mid_rst_valid", power_valid, 0);
      chk("mid_rst_ready", in_ready, 0);
      chk("mid_rst_overrun", overrun, 0);
      rst = 1'b0;
      repeat (15) tick();
      chk("mid_rst_nores", got_pow.size(), 0);
      chk("mid_rst_rises", rises - q0, 0);
      start(0);
      send(9, 0);
      collect("len0", 81, 1);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/square_accum_window_ctrl.md
SQUARE_ACCUM_WINDOW_CTRL -- requirements
Module: square_accum_window_ctrl

Interface
REQ-001 The block SHALL have parameter LEN_WIDTH, default 16: width of the window-length input and sample counter.
REQ-002 The block SHALL have parameter ACC_LATENCY, default 3: clock-enabled cycles from square_5bit_accumulator in_i to accum_o.
REQ-003 The block SHALL have port clk_i  input  1  as its single clock.
REQ-004 The block SHALL have port rst_i  input  1  as its synchronous active-high reset.
REQ-005 The block SHALL have port en_i  input  1  to run windows continuously while high.
REQ-006 The block SHALL have port win_len_i  input  LEN_WIDTH  carrying samples per window, latched at window start.
REQ-007 The block SHALL have ports in_i  input  4  (sample magnitude), in_valid_i  input  1, and in_ready_o  output  1.
REQ-008 The block SHALL have ports power_o  output  24  (raw accumulator result) and count_o  output  LEN_WIDTH  (samples in that result).
REQ-009 The block SHALL have ports power_valid_o  output  1  and power_ready_i  input  1.
REQ-010 The block SHALL have port overrun_o  output  1  as a sticky result-overwrite flag.

Function
REQ-011 The FSM SHALL have states IDLE, RUN, DRAIN, CAPTURE, HOLD and CLR.
- IDLE -> RUN when en_i=1.
- On IDLE -> RUN, latch win_len_i, with 0 treated as 1, and zero the counter.
REQ-012 in_ready_o SHALL equal (state==RUN).
- A sample is accepted when in_valid_i & in_ready_o.
- An accepted sample drives accumulator ce=1 with in=in_i; otherwise in RUN, ce=0.
REQ-013 The accepted sample that makes count equal the latched length SHALL move the FSM RUN -> DRAIN.
REQ-014 DRAIN SHALL last exactly ACC_LATENCY cycles, with ce=1 and in=0, then go to CAPTURE.
REQ-015 CAPTURE SHALL register accum_o into power_o and the count into count_o, and set power_valid_o on the next edge.
- Result latency: power_valid_o rises ACC_LATENCY+2 edges after the edge accepting the last sample.
REQ-016 HOLD SHALL drive ce=0 for one cycle; CLR SHALL drive accumulator rst=1 with ce=0 for one cycle.
- After CLR: RUN with a fresh length latch if en_i=1, else IDLE.
REQ-017 power_valid_o SHALL stay high until power_ready_i=1, then clear on that edge.
- A pending result that is consumed in the same cycle as CAPTURE counts as a free slot.
REQ-018 If en_i falls in RUN, the FSM SHALL abort to HOLD -> CLR -> IDLE with no capture.
- If en_i falls in DRAIN, the window SHALL complete and be captured.
REQ-019 The counter SHALL never wrap, since the maximum length 2^LEN_WIDTH-1 terminates the window first.

Reset
REQ-020 While rst_i=1:
- The accumulator rst SHALL be driven high and ce low.
- The FSM SHALL go to IDLE.
- power_o, count_o, power_valid_o and overrun_o SHALL be 0.
- in_ready_o SHALL be 0 on the following cycle.
REQ-021 rst_i asserted mid-window SHALL discard the partial window; rst_i takes priority over all other events.

Configuration
REQ-022 With macro SQACC_CTRL_OVERRUN_EN defined, CAPTURE onto an unconsumed result SHALL overwrite it and set overrun_o.
- overrun_o stays set until rst_i.
REQ-023 Without SQACC_CTRL_OVERRUN_EN, CAPTURE SHALL stall until the output slot is free, and overrun_o SHALL be tied 0.
- During the stall, ce=0 and in_ready_o=0.

Structure
REQ-024 Package sqacc_ctrl_pkg SHALL hold the state enum, IN_WIDTH=4 and ACC_WIDTH=24.
REQ-025 The block SHALL instantiate exactly one square_5bit_accumulator sub-module, driving its ce_i, rst_i and in_i.

Verification
REQ-026 Scenario: win_len=2, samples 1, 2.
- count_o=2.
- power_o SHALL equal a golden square_5bit_accumulator fed 1, 2 after reset.
- power_valid_o rises ACC_LATENCY+2 edges after the second sample.
REQ-027 Scenario: win_len=16, samples 0..15 with in_valid_i gaps every third cycle.
- power_o SHALL match the golden model; count_o=16.
- Gap cycles show ce=0.
REQ-028 Scenario: en_i held, win_len=4, power_ready_i=1, 3 windows of value 7.
- Three identical results.
- in_ready_o low for exactly ACC_LATENCY+3 cycles between windows.
REQ-029 Scenario: power_ready_i=0 across two windows.
- With the macro: second result overwrites the first and overrun_o=1.
- Without the macro: FSM stalls in CAPTURE with in_ready_o=0 until ready=1, and the first result is preserved.
REQ-030 Scenario: en_i drops after 3 of 8 samples.
- No power_valid_o.
- Accumulator rst pulses once.
- Re-enable with win_len=1, sample 5 -> golden result for the single sample 5, count_o=1.
REQ-031 Scenario: rst_i mid-DRAIN.
- All outputs 0 next cycle; no result.
- win_len=0 then 1 sample -> count_o=1.
